fetch_if_id: RTL and testbench
==============================

// Module: fetch_if_id
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the ID/EX register.
//  Owns the PC, fetches from a variable-latency instruction memory over a req/ack handshake, and
//  presents {instru, nextPc, valid} to decode/ID-EX. Supports hazard-unit stall and branch/jump flush.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction word driven on instru for a bubble (sll $0,$0,0)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst_n        in   1   asynchronous active-low reset
//  stall        in   1   hazard unit: hold IF/ID outputs and PC this cycle
//  flush        in   1   taken branch/jump resolved downstream: redirect fetch, squash IF/ID
//  redirect_pc  in   32  target PC, sampled only when flush=1; bits [1:0] forced to 2'b00
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  fetch address (= internal PC)
//  imem_ack     in   1   memory returns imem_rdata this cycle (may be same cycle as req)
//  imem_rdata   in   32  fetched instruction word, valid only when imem_ack=1
//  instru       out  32  IF/ID instruction to decode and ID/EX register
//  nextPc       out  32  IF/ID PC+4 of instru
//  valid        out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, instru=NOP_INSTR, nextPc=0, valid=0,
//   buffer cleared; imem_req forced 0 while rst_n=0. First request in the cycle after release.
//  States: FETCH (req=1, awaiting ack), HOLD (req=0, word buffered, stalled), DROP (req=1,
//   stale request outstanding after flush). imem_addr=pc; pc and addr constant while req=1 & !ack.
//  Priority each cycle: flush > stall > normal. flush always writes bubble (NOP_INSTR, valid=0)
//   into IF/ID even if stall=1. stall with no flush leaves instru/nextPc/valid unchanged.
//  FETCH, ack=1: flush -> discard word, pc<=redirect_pc, stay FETCH.
//   stall -> word to buffer (bufInstr, bufNext=pc+4), go HOLD.
//   else -> IF/ID<={imem_rdata, pc+4, 1}, pc<=pc+4, stay FETCH (1 instr/cycle at ack latency 0).
//  FETCH, ack=0: flush -> pending<=redirect_pc, go DROP. stall -> hold. else -> IF/ID bubble.
//  HOLD: flush -> drop buffer, pc<=redirect_pc, go FETCH. stall -> hold.
//   else -> IF/ID<={bufInstr, bufNext, 1}, pc<=pc+4, go FETCH.
//  DROP: req stays on old addr. flush again -> pending<=redirect_pc (latest wins).
//   ack=1 -> word discarded, pc<=pending (or redirect_pc if flush same cycle), go FETCH.
//   IF/ID bubble while in DROP unless stall (stall holds the bubble already present).
//  Arithmetic: pc+4 modulo 2^32; pc=32'hFFFF_FFFC increments to 32'h0000_0000.
//  A word returned while in FETCH is never lost: accepted, buffered, or deliberately squashed.
//  Reset asserted mid-request: state abandoned immediately; outstanding ack after release ignored
//   only if it arrives before the new req (memory must not ack without req).
// TESTING
//  1. Reset, ack tied 1, no stall/flush -> instru = mem[0],mem[4],mem[8]... one per cycle,
//     nextPc=4,8,12, valid=1 from 2nd cycle after release.
//  2. ack latency 2 cycles -> valid pulses 1 every 3rd cycle, bubbles (NOP, valid=0) between,
//     imem_addr stable while waiting.
//  3. stall for 3 cycles arriving with ack -> IF/ID frozen, req=0 in HOLD; on release buffered
//     word appears next cycle, PC sequence unbroken (no skip, no duplicate).
//  4. flush with redirect_pc=32'h0000_0040 while ack=0 -> DROP; old word discarded on ack,
//     next valid instru = mem[0x40], nextPc=0x44; valid=0 in between.
//  5. flush and stall same cycle in HOLD -> bubble written, buffer dropped, fetch from redirect_pc.
//  6. RESET_PC=32'hFFFF_FFFC -> nextPc of first instr = 0, second fetch addr = 0.

Source files
------------

// File: rtl/fetch_if_id.sv
// fetch_if_id: instruction-fetch stage plus IF/ID pipeline register.
// Owns the PC, fetches over a req/ack handshake from a variable-latency
// instruction memory, and presents {instru, nextPc, valid} to decode.
// Supports hazard stall and branch/jump flush (flush > stall > normal).
//
// Ports:
//   clk, rst_n           clock / async active-low reset
//   stall                hold IF/ID outputs and PC this cycle
//   flush, redirect_pc   squash IF/ID and redirect fetch (target word-aligned)
//   imem_req, imem_addr  fetch request / address (= pc)
//   imem_ack, imem_rdata memory response (may arrive in the request cycle)
//   instru, nextPc, valid IF/ID register contents (valid=0 is a bubble)
//
// state | meaning
// FETCH | request outstanding at pc, waiting for ack
// HOLD  | fetched word buffered while stalled, no request
// DROP  | stale request outstanding after flush; its word will be discarded
module fetch_if_id #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instru,
  output logic [31:0] nextPc,
  output logic        valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_next_q, buf_next_d;
  logic [31:0] instru_d, next_pc_d;
  logic        valid_d;
  logic [31:0] pc_inc;
  logic [31:0] redir;

  assign pc_inc = pc_q + 32'd4;
  assign redir  = {redirect_pc[31:2], 2'b00};

  // req is gated by rst_n so nothing is requested while reset is held.
  assign imem_req  = rst_n & (state_q != HOLD);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_q      <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_next_q  <= 32'd0;
      instru      <= NOP_INSTR;
      nextPc      <= 32'd0;
      valid       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      buf_instr_q <= buf_instr_d;
      buf_next_q  <= buf_next_d;
      instru      <= instru_d;
      nextPc      <= next_pc_d;
      valid       <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    buf_instr_d = buf_instr_q;
    buf_next_d  = buf_next_q;
    instru_d    = instru;
    next_pc_d   = nextPc;
    valid_d     = valid;

    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          if (flush) begin
            instru_d = NOP_INSTR;
            valid_d  = 1'b0;
            pc_d     = redir;
          end else if (stall) begin
            // Park the word so it is not lost while decode is frozen.
            buf_instr_d = imem_rdata;
            buf_next_d  = pc_inc;
            state_d     = HOLD;
          end else begin
            instru_d  = imem_rdata;
            next_pc_d = pc_inc;
            valid_d   = 1'b1;
            pc_d      = pc_inc;
          end
        end else begin
          if (flush) begin
            // Request cannot be withdrawn; remember target until it returns.
            instru_d = NOP_INSTR;
            valid_d  = 1'b0;
            pend_d   = redir;
            state_d  = DROP;
          end else if (!stall) begin
            instru_d = NOP_INSTR;
            valid_d  = 1'b0;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          instru_d    = NOP_INSTR;
          valid_d     = 1'b0;
          buf_instr_d = 32'd0;
          buf_next_d  = 32'd0;
          pc_d        = redir;
          state_d     = FETCH;
        end else if (!stall) begin
          instru_d  = buf_instr_q;
          next_pc_d = buf_next_q;
          valid_d   = 1'b1;
          pc_d      = pc_inc;
          state_d   = FETCH;
        end
      end

      DROP: begin
        if (flush) begin
          instru_d = NOP_INSTR;
          valid_d  = 1'b0;
          pend_d   = redir;
        end else if (!stall) begin
          instru_d = NOP_INSTR;
          valid_d  = 1'b0;
        end
        if (imem_ack) begin
          pc_d    = flush ? redir : pend_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_if_id.sv
module tb_fetch_if_id;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int K_EITHER = 0;
  localparam int K_BUBBLE = 1;
  localparam int K_HOLD   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instru, nextPc;
  logic        valid;

  logic        w_req;
  logic [31:0] w_addr, w_rdata, w_instru, w_next;
  logic        w_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  fetch_if_id dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instru(instru),
    .nextPc(nextPc), .valid(valid)
  );

  // Second instance exercising PC wraparound with a zero-latency memory.
  assign w_rdata = mem_word(w_addr);
  fetch_if_id #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .flush(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(w_rdata), .instru(w_instru),
    .nextPc(w_next), .valid(w_valid)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    int          kind;
    logic [31:0] redir;
    int          want;
  } exp_t;
  exp_t sb[$];

  // Memory model state
  int          cnt, lat, lat_mode;
  bit          pend;
  logic [31:0] last_addr;

  // One cycle of stimulus; called just after a negedge. want: -1 don't care,
  // 0/1 exact valid, 2 valid must equal this cycle's ack.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] rp, input int want);
    logic        req, ack;
    logic [31:0] addr;
    exp_t        e;
    stall = st; flush = fl; redirect_pc = rp;
    req  = imem_req;
    addr = imem_addr;
    ack  = req && (cnt == lat);
    if (req && pend) chk("addr_stable", addr, last_addr);
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(addr) : $urandom;
    e.kind  = fl ? K_BUBBLE : (st ? K_HOLD : K_EITHER);
    e.redir = {rp[31:2], 2'b00};
    e.want  = (want == 2) ? (ack ? 1 : 0) : want;
    sb.push_back(e);
    @(posedge clk);
    if (req && ack) begin
      cnt  = 0;
      pend = 1'b0;
      lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end else if (req) begin
      cnt++;
      pend = 1'b1;
      last_addr = addr;
    end else begin
      pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_lat(input int v);
    for (int i = 0; i < 10 && cnt != 0; i++) cycle(1'b0, 1'b0, 32'h0, -1);
    lat_mode = v;
    lat = v;
  endtask

  // Monitor / reference model: expected stream of instruction addresses.
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] p_instru = NOP, p_next = 32'h0;
  logic        p_valid = 1'b0;
  int          n_valid = 0;

  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        if (r.kind == K_BUBBLE) begin
          chk("flush_valid", valid, 1'b0);
          chk("flush_instru", instru, NOP);
          exp_pc = r.redir;
        end else if (r.kind == K_HOLD) begin
          chk("stall_valid", valid, p_valid);
          chk("stall_instru", instru, p_instru);
          chk("stall_nextpc", nextPc, p_next);
        end else begin
          if (r.want == 1) chk("want_valid", valid, 1'b1);
          if (r.want == 0) chk("want_bubble", valid, 1'b0);
          if (valid) begin
            chk("instru", instru, mem_word(exp_pc));
            chk("nextpc", nextPc, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_valid++;
          end else begin
            chk("bubble_instru", instru, NOP);
          end
        end
      end
      p_instru = instru;
      p_next   = nextPc;
      p_valid  = valid;
    end
  end

  // Wraparound instance checks
  initial begin
    @(posedge rst_n);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_valid1", w_valid, 1'b1);
    chk("wrap_instru1", w_instru, mem_word(32'hFFFF_FFFC));
    chk("wrap_next1", w_next, 32'h0);
    chk("wrap_addr1", w_addr, 32'h0);
    @(posedge clk); #1;
    chk("wrap_instru2", w_instru, mem_word(32'h0));
    chk("wrap_next2", w_next, 32'h4);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    cnt = 0; lat = 0; lat_mode = 0; pend = 1'b0; last_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_instru", instru, NOP);
    chk("rst_nextpc", nextPc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Zero latency: one instruction per cycle.
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 2);
    // Latency 2: valid every third cycle, bubbles between.
    lat_mode = 2; lat = 2;
    repeat (9) cycle(1'b0, 1'b0, 32'h0, 2);

    // Stall 3 cycles arriving with ack, then release delivers buffered word.
    set_lat(0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, -1);
    chk("hold_req", imem_req, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 2);

    // Flush while ack=0 -> DROP, stale word discarded, resume at 0x40.
    set_lat(2);
    cycle(1'b0, 1'b1, 32'h0000_0040, -1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 0);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 2);

    // Flush and stall together while in HOLD.
    set_lat(0);
    cycle(1'b1, 1'b0, 32'h0, -1);
    cycle(1'b1, 1'b1, 32'h0000_0103, -1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 2);

    // Randomized traffic.
    lat_mode = -1;
    repeat (400) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom, -1);
    end
    repeat (8) cycle(1'b0, 1'b0, 32'h0, -1);

    chk("liveness", (n_valid > 60) ? 32'd1 : 32'd0, 32'd1);

    // Async reset takes effect without a clock edge.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", imem_req, 1'b0);
    chk("async_rst_valid", valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
